fir_sched: RTL and testbench

Host-facing controller that sequences the tapped FIR core. It accepts a byte-wide request stream with a mode bit and does two jobs:
- Collects coefficient bytes into a shadow bank, then replays them into the FIR's serial coefficient-shift port with the required ordering.
- Issues one sample per request to the FIR, waits the fixed FIR latency, then captures the result with a one-cycle valid pulse.

It sits between the chip's input pins and the FIR datapath. It is the only driver of the FIR's valid and coefficient-load inputs.

---
 rtl/fir_pkg.sv | 14 +
 rtl/fir_coef_bank.sv | 40 ++++
 rtl/fir_sched.sv | 154 +++++++++++++++
 tb/tb_fir_sched.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding, request modes and FIR defaults for the FIR sequencer
package fir_pkg;
  typedef enum logic [2:0] {
    IDLE,
    COEF_COLLECT,
    COEF_SHIFT,
    COEF_SETTLE,
    SAMPLE_RUN,
    SAMPLE_CAPTURE
  } state_t;
  localparam logic MODE_SAMPLE = 1'b0;
  localparam logic MODE_COEF = 1'b1;
  localparam int FIR_LATENCY_DEF = 6;
endpackage

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: shadow coefficient registers with write/read pointers and a full flag
module fir_coef_bank #(
  parameter int NBR_OF_TAPS = 3,
  parameter int TAP_SIZE = 3,
  parameter int CW = $clog2(NBR_OF_TAPS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                wr_en,
  input  logic                wr_restart,
  input  logic [TAP_SIZE-1:0] wr_data,
  input  logic                rd_load,
  input  logic                rd_dec,
  output logic [CW-1:0]       wr_ptr,
  output logic [CW-1:0]       rd_ptr,
  output logic [TAP_SIZE-1:0] rd_next,
  output logic                full
);
  logic [TAP_SIZE-1:0] mem [NBR_OF_TAPS];
  logic [CW-1:0] wr_idx;
  assign wr_idx = wr_restart ? '0 : wr_ptr;
  assign full = wr_ptr == CW'(NBR_OF_TAPS);
  // rd_ptr names the coefficient on the bus now; rd_next is the one that follows it
  assign rd_next = (rd_ptr == '0) ? '0 : mem[rd_ptr - CW'(1)];
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      mem <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_idx] <= wr_data;
        wr_ptr <= wr_idx + 1'b1;
      end
      if (rd_load) rd_ptr <= CW'(NBR_OF_TAPS - 1);
      else if (rd_dec) rd_ptr <= rd_ptr - 1'b1;
    end
  end
endmodule

// File: rtl/fir_sched.sv
// fir_sched: host request sequencer that loads FIR coefficients and runs samples through the FIR
module fir_sched
  import fir_pkg::*;
#(
  parameter int NBR_OF_TAPS = 3,
  parameter int TAP_SIZE = 3,
  parameter int X_N_SIZE = 8,
  parameter int Y_N_SIZE = 11,
  parameter int FIR_LATENCY = FIR_LATENCY_DEF,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [X_N_SIZE-1:0] req_data,
  input  logic                req_mode,
  input  logic                req_valid,
  output logic                req_ready,
  output logic [X_N_SIZE-1:0] fir_x_n,
  output logic                fir_tvalid,
  output logic                fir_set_coeffs,
  input  logic [Y_N_SIZE-1:0] fir_y_n,
  output logic [Y_N_SIZE-1:0] res_data,
  output logic                res_valid,
  output logic                err,
  output logic                busy
);
  localparam int CW = $clog2(NBR_OF_TAPS + 1);
  localparam int LW = $clog2(FIR_LATENCY + 1);
  localparam int SW = SETTLE_CYCLES > 0 ? $clog2(SETTLE_CYCLES + 1) : 1;

  state_t state, state_d;
  logic [LW-1:0] lat_cnt, lat_cnt_d;
  logic [SW-1:0] settle_cnt, settle_cnt_d;
  logic [X_N_SIZE-1:0] x_d;
  logic [Y_N_SIZE-1:0] res_d;
  logic tvalid_d, set_d, rv_d, err_d, xfer;
  logic wr_en, wr_restart, clear, rd_load, rd_dec, bank_full;
  logic [CW-1:0] coef_cnt, shift_idx;
  logic [TAP_SIZE-1:0] rd_next;

  function automatic logic [X_N_SIZE-1:0] sext(input logic [TAP_SIZE-1:0] v);
    return {{(X_N_SIZE - TAP_SIZE){v[TAP_SIZE-1]}}, v};
  endfunction

  assign xfer = req_valid && req_ready;

  fir_coef_bank #(.NBR_OF_TAPS(NBR_OF_TAPS), .TAP_SIZE(TAP_SIZE), .CW(CW)) u_bank (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .wr_en(wr_en),
    .wr_restart(wr_restart),
    .wr_data(req_data[TAP_SIZE-1:0]),
    .rd_load(rd_load),
    .rd_dec(rd_dec),
    .wr_ptr(coef_cnt),
    .rd_ptr(shift_idx),
    .rd_next(rd_next),
    .full(bank_full)
  );

  always_comb begin
    state_d = state;
    lat_cnt_d = lat_cnt;
    settle_cnt_d = settle_cnt;
    x_d = fir_x_n;
    res_d = res_data;
    tvalid_d = 1'b0;
    set_d = 1'b0;
    rv_d = 1'b0;
    err_d = err;
    wr_en = 1'b0;
    wr_restart = 1'b0;
    clear = 1'b0;
    rd_load = 1'b0;
    rd_dec = 1'b0;
    case (state)
      IDLE, COEF_COLLECT: if (xfer) begin
        if (req_mode == MODE_COEF) begin
          wr_en = 1'b1;
          wr_restart = state == IDLE;
          // the final byte is forwarded straight to the bus while it is being written
          if (state == IDLE ? NBR_OF_TAPS == 1 : coef_cnt == CW'(NBR_OF_TAPS - 1)) begin
            state_d = COEF_SHIFT;
            set_d = 1'b1;
            x_d = sext(req_data[TAP_SIZE-1:0]);
            rd_load = 1'b1;
          end else state_d = COEF_COLLECT;
        end else if (state == IDLE) begin
          state_d = SAMPLE_RUN;
          x_d = req_data;
          tvalid_d = 1'b1;
          lat_cnt_d = '0;
        end else begin
          state_d = IDLE;
          err_d = 1'b1;
          clear = 1'b1;
        end
      end
      COEF_SHIFT: if (shift_idx == '0) begin
        state_d = (SETTLE_CYCLES == 0) ? IDLE : COEF_SETTLE;
        settle_cnt_d = '0;
        x_d = '0;
      end else begin
        set_d = 1'b1;
        x_d = sext(rd_next);
        rd_dec = 1'b1;
      end
      COEF_SETTLE: if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state_d = IDLE;
        else settle_cnt_d = settle_cnt + 1'b1;
      SAMPLE_RUN: begin
        lat_cnt_d = lat_cnt + 1'b1;
        if (lat_cnt == LW'(FIR_LATENCY - 1)) begin
          state_d = SAMPLE_CAPTURE;
          res_d = fir_y_n;
          rv_d = 1'b1;
        end else tvalid_d = 1'b1;
      end
      SAMPLE_CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      lat_cnt <= '0;
      settle_cnt <= '0;
      req_ready <= 1'b1;
      fir_x_n <= '0;
      fir_tvalid <= 1'b0;
      fir_set_coeffs <= 1'b0;
      res_data <= '0;
      res_valid <= 1'b0;
      err <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_d;
      lat_cnt <= lat_cnt_d;
      settle_cnt <= settle_cnt_d;
      req_ready <= state_d == IDLE || state_d == COEF_COLLECT;
      fir_x_n <= x_d;
      fir_tvalid <= tvalid_d;
      fir_set_coeffs <= set_d;
      res_data <= res_d;
      res_valid <= rv_d;
      err <= err_d;
      busy <= state_d != IDLE;
    end
  end

  a_excl: assert property (@(posedge clk) !(fir_tvalid && fir_set_coeffs));
  a_full: assert property (@(posedge clk) disable iff (reset) state == COEF_SHIFT |-> bank_full);
endmodule

// File: tb/tb_fir_sched.sv
// tb_fir_sched: randomized scoreboard bench for fir_sched with a protocol-level reference model
module tb_fir_sched;
  localparam int N = 3;
  localparam int LAT = 6;
  localparam int SET = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] req_data = '0;
  logic req_mode = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [7:0] fir_x_n;
  logic fir_tvalid, fir_set_coeffs;
  logic [10:0] fir_y_n = '0;
  logic [10:0] res_data;
  logic res_valid, err, busy;

  fir_sched #(
    .NBR_OF_TAPS(N), .TAP_SIZE(3), .X_N_SIZE(8), .Y_N_SIZE(11),
    .FIR_LATENCY(LAT), .SETTLE_CYCLES(SET)
  ) dut (
    .clk(clk), .reset(reset), .req_data(req_data), .req_mode(req_mode),
    .req_valid(req_valid), .req_ready(req_ready), .fir_x_n(fir_x_n),
    .fir_tvalid(fir_tvalid), .fir_set_coeffs(fir_set_coeffs), .fir_y_n(fir_y_n),
    .res_data(res_data), .res_valid(res_valid), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int last_acc = 0;
  logic exp_err = 1'b0;
  logic [7:0] exp_coef[$];
  logic [7:0] exp_samp[$];
  logic [10:0] exp_res[$];
  logic [2:0] cbuf[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: unexpected event, value 0x%0h", name, act);
  endtask

  function automatic logic [10:0] fir_resp(input logic [7:0] x);
    return 11'(x * 37 + 51);
  endfunction

  function automatic logic [7:0] sext3(input logic [2:0] v);
    return {{5{v[2]}}, v};
  endfunction

  // FIR stand-in: output is only meaningful once tvalid has been high for LAT cycles
  int k = 0;
  always @(negedge clk) begin
    k = fir_tvalid ? k + 1 : 0;
    fir_y_n = (k >= LAT) ? fir_resp(fir_x_n) : 11'($urandom);
  end

  int run = 0;
  logic prev_rv = 1'b0;
  logic [7:0] held = '0;
  always @(negedge clk) begin
    if (reset) begin
      run = 0;
      prev_rv = 1'b0;
    end else begin
      if (fir_tvalid || fir_set_coeffs) chk("ctrl_exclusive", 32'(fir_tvalid && fir_set_coeffs), 0);
      if (fir_set_coeffs) begin
        if (exp_coef.size() == 0) bad("coef_unexpected", fir_x_n);
        else chk("coef_x_n", fir_x_n, exp_coef.pop_front());
      end
      if (fir_tvalid) begin
        if (run == 0) begin
          if (exp_samp.size() == 0) begin
            bad("tvalid_unexpected", fir_x_n);
            held = fir_x_n;
          end else held = exp_samp.pop_front();
        end
        chk("tvalid_x_n", fir_x_n, held);
        run++;
      end else if (run > 0) begin
        chk("tvalid_len", run, LAT);
        run = 0;
      end
      if (res_valid) begin
        if (prev_rv) bad("res_valid_len", res_data);
        if (exp_res.size() == 0) bad("res_unexpected", res_data);
        else chk("res_data", res_data, exp_res.pop_front());
      end
      prev_rv = res_valid;
    end
  end

  task automatic send(input logic m, input logic [7:0] d);
    int w = 0;
    req_valid = 1'b1;
    req_mode = m;
    req_data = d;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      bad("accept_timeout", w);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (m) begin
      cbuf.push_back(d[2:0]);
      if (cbuf.size() == N) begin
        for (int i = N - 1; i >= 0; i--) exp_coef.push_back(sext3(cbuf[i]));
        cbuf.delete();
      end
    end else if (cbuf.size() > 0) begin
      exp_err = 1'b1;
      cbuf.delete();
    end else begin
      exp_samp.push_back(d);
      exp_res.push_back(fir_resp(d));
    end
    @(negedge clk);
    last_acc = cyc;
  endtask

  task automatic wait_idle(output int n);
    n = 1;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) bad("idle_timeout", n);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tvalid"}, fir_tvalid, 0);
    chk({tag, "_set"}, fir_set_coeffs, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_x_n"}, fir_x_n, 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    exp_coef.delete();
    cbuf.delete();
    exp_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, a1, reps;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk_reset_outputs("idle");

    send(1'b1, 8'h05);
    send(1'b1, 8'h02);
    send(1'b1, 8'h03);
    req_valid = 1'b0;
    wait_idle(n);
    chk("coef_busy_len", n, N + SET + 1);

    send(1'b0, 8'h0A);
    req_valid = 1'b0;
    wait_idle(n);
    chk("sample_busy_len", n, LAT + 2);
    chk("res_hold", res_data, 11'h1A5);

    send(1'b1, 8'hF1);
    send(1'b1, 8'h3C);
    send(1'b1, 8'h66);
    req_valid = 1'b0;
    @(negedge clk);
    chk("shift2_set", fir_set_coeffs, 1);
    pulse_reset();
    chk_reset_outputs("mid_shift_reset");
    reset = 1'b0;

    send(1'b1, 8'h04);
    req_valid = 1'b0;
    pulse_reset();
    reset = 1'b0;
    send(1'b0, 8'h22);
    req_valid = 1'b0;
    wait_idle(n);
    chk("discard_busy_len", n, LAT + 2);
    chk("discard_err", err, 0);

    send(1'b0, 8'h01);
    a1 = last_acc;
    send(1'b0, 8'h7F);
    chk("b2b_gap", last_acc - a1, LAT + 2);
    req_valid = 1'b0;
    wait_idle(n);

    send(1'b1, 8'h07);
    send(1'b0, 8'h10);
    req_valid = 1'b0;
    wait_idle(n);
    chk("err_busy_len", n, 1);
    chk("err_set", err, 1);
    send(1'b0, 8'h10);
    req_valid = 1'b0;
    wait_idle(n);
    chk("post_err_len", n, LAT + 2);
    chk("err_sticky", err, 1);

    pulse_reset();
    reset = 1'b0;
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) begin
        for (int j = 0; j < N; j++) begin
          send(1'b1, 8'($urandom));
          if ($urandom_range(0, 2) == 0) begin
            req_valid = 1'b0;
            @(negedge clk);
          end
        end
      end else if (r < 9) send(1'b0, 8'($urandom));
      else begin
        reps = $urandom_range(1, N - 1);
        for (int j = 0; j < reps; j++) send(1'b1, 8'($urandom));
        send(1'b0, 8'($urandom));
      end
      req_valid = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        wait_idle(n);
        chk("rand_err", err, exp_err);
      end
    end

    wait_idle(n);
    repeat (10) @(negedge clk);
    chk("coef_q_empty", exp_coef.size(), 0);
    chk("samp_q_empty", exp_samp.size(), 0);
    chk("res_q_empty", exp_res.size(), 0);
    chk("err_final", err, exp_err);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
